// File: rtl/dbg_pkg.sv
// Shared constants, link codes and FSM state encoding for the debug unit controller.
package dbg_pkg;

    localparam int NB_REG       = 32;
    localparam int NB_BYTE      = 8;
    localparam int N_INST_WORDS = 128;
    localparam int N_REGS       = 32;
    localparam int N_MEM_WORDS  = 32;

    localparam int NB_WCNT = $clog2(N_INST_WORDS + 1);
    localparam int NB_IDX  = $clog2(N_REGS + N_MEM_WORDS);

    localparam logic [NB_BYTE-1:0] CMD_LOAD   = 8'h4C;
    localparam logic [NB_BYTE-1:0] CMD_CONT   = 8'h43;
    localparam logic [NB_BYTE-1:0] CMD_STEP   = 8'h53;
    localparam logic [NB_BYTE-1:0] CMD_RSTPC  = 8'h52;
    localparam logic [NB_BYTE-1:0] CMD_ABORT  = 8'h58;
    localparam logic [NB_BYTE-1:0] CODE_ACK   = 8'hAA;
    localparam logic [NB_BYTE-1:0] CODE_NAK   = 8'h15;
    localparam logic [NB_BYTE-1:0] TRAIL_HALT = 8'h48;
    localparam logic [NB_BYTE-1:0] TRAIL_RUN  = 8'h53;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_LEN,
        LOAD_BYTE,
        LOAD_WRITE,
        RST_PC,
        RUN,
        STEP,
        DUMP_ADDR,
        DUMP_WAIT,
        DUMP_TX,
        SEND_BYTE
    } state_t;

    // Word index to byte address on the 32-bit debug bus.
    function automatic logic [NB_REG-1:0] word_addr(input logic [NB_REG-1:0] idx);
        return idx << 2;
    endfunction

endpackage

// File: rtl/debug_unit_ctrl_if.sv
// Byte link plus pipeline debug port, seen from the controller (master) and the environment (slave).
interface debug_unit_ctrl_if import dbg_pkg::*;;

    logic [NB_BYTE-1:0] i_rx_data;
    logic               i_rx_valid;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_valid;
    logic               i_tx_ready;
    logic               i_halt;
    logic [NB_REG-1:0]  i_dunit_reg;
    logic [NB_REG-1:0]  i_dunit_mem_data;
    logic               o_dunit_clk_en;
    logic               o_dunit_reset_pc;
    logic               o_dunit_w_mem;
    logic [NB_REG-1:0]  o_dunit_addr;
    logic [NB_REG-1:0]  o_dunit_data_if;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_dunit_reg, i_dunit_mem_data,
        output o_tx_data, o_tx_valid, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem,
               o_dunit_addr, o_dunit_data_if
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_ready, i_halt, i_dunit_reg, i_dunit_mem_data,
        input  o_tx_data, o_tx_valid, o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem,
               o_dunit_addr, o_dunit_data_if
    );

endinterface

// File: rtl/dbg_word_tx.sv
// Serializes a 32-bit word MSB first (or a single byte) onto a valid/ready byte link.
module dbg_word_tx import dbg_pkg::*; (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_single,
    input  logic [NB_REG-1:0]  i_word,
    input  logic               i_tx_ready,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    output logic               o_done
);

    logic [NB_REG-1:0] r_shift;
    logic [1:0]        r_cnt;
    logic              r_valid;
    logic              r_done;

    // Start is honoured only while idle; o_done pulses the cycle after the last byte is accepted.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_shift <= '0;
            r_cnt   <= 2'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_valid) begin
                if (i_start) begin
                    r_valid <= 1'b1;
                    r_cnt   <= i_single ? 2'd0 : 2'd3;
                    r_shift <= i_single ? {i_word[NB_BYTE-1:0], {(NB_REG-NB_BYTE){1'b0}}} : i_word;
                end
            end else if (i_tx_ready) begin
                if (r_cnt == 2'd0) begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_cnt   <= r_cnt - 2'd1;
                    r_shift <= {r_shift[NB_REG-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
                end
            end
        end
    end

    assign o_tx_data  = r_shift[NB_REG-1 -: NB_BYTE];
    assign o_tx_valid = r_valid;
    assign o_done     = r_done;

endmodule

// File: rtl/debug_unit_ctrl.sv
// Command sequencer: loads instruction memory, runs/steps the pipeline and dumps registers and data memory.
module debug_unit_ctrl import dbg_pkg::*; (
    input  logic               i_clk,
    input  logic               i_reset,
    debug_unit_ctrl_if.master  bus,
    output logic [3:0]         o_state
);

    state_t             r_state;
    state_t             w_next;
    logic [NB_WCNT-1:0] r_word_cnt;
    logic [NB_WCNT-1:0] r_len;
    logic [1:0]         r_byte_cnt;
    logic [NB_REG-1:0]  r_word;
    logic [NB_IDX-1:0]  r_idx;

    logic               w_start;
    logic               w_single;
    logic [NB_REG-1:0]  w_tx_word;
    logic               w_done;
    logic               w_is_mem;
    logic               w_last_idx;
    logic               w_len_ok;
    logic [NB_REG-1:0]  w_dump_addr;

    assign w_is_mem    = (r_idx >= NB_IDX'(N_REGS));
    assign w_last_idx  = (r_idx == NB_IDX'(N_REGS + N_MEM_WORDS - 1));
    assign w_len_ok    = (bus.i_rx_data != '0) && (NB_REG'(bus.i_rx_data) <= NB_REG'(N_INST_WORDS));
    assign w_dump_addr = w_is_mem ? word_addr(NB_REG'(r_idx - NB_IDX'(N_REGS))) : NB_REG'(r_idx);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Every single-byte reply (ACK, NAK, trailer) goes out through the serializer's 1-byte mode.
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_single  = 1'b0;
        w_tx_word = '0;
        unique case (r_state)
            IDLE: if (bus.i_rx_valid) begin
                case (bus.i_rx_data)
                    CMD_LOAD:  w_next = LOAD_LEN;
                    CMD_CONT:  w_next = bus.i_halt ? DUMP_ADDR : RUN;
                    CMD_STEP:  w_next = bus.i_halt ? DUMP_ADDR : STEP;
                    CMD_RSTPC: w_next = RST_PC;
                    default: begin
                        w_start   = 1'b1;
                        w_single  = 1'b1;
                        w_tx_word = NB_REG'(CODE_NAK);
                        w_next    = SEND_BYTE;
                    end
                endcase
            end
            LOAD_LEN: if (bus.i_rx_valid) begin
                if (w_len_ok) begin
                    w_next = LOAD_BYTE;
                end else begin
                    w_start   = 1'b1;
                    w_single  = 1'b1;
                    w_tx_word = NB_REG'(CODE_NAK);
                    w_next    = SEND_BYTE;
                end
            end
            LOAD_BYTE:  if (bus.i_rx_valid && r_byte_cnt == 2'd3) w_next = LOAD_WRITE;
            LOAD_WRITE: w_next = (NB_WCNT'(r_word_cnt + 1'b1) == r_len) ? RST_PC : LOAD_BYTE;
            RST_PC: begin
                w_start   = 1'b1;
                w_single  = 1'b1;
                w_tx_word = NB_REG'(CODE_ACK);
                w_next    = SEND_BYTE;
            end
            RUN: if (bus.i_halt || (bus.i_rx_valid && bus.i_rx_data == CMD_ABORT)) w_next = DUMP_ADDR;
            STEP:      w_next = DUMP_ADDR;
            DUMP_ADDR: w_next = DUMP_WAIT;
            DUMP_WAIT: begin
                w_start   = 1'b1;
                w_tx_word = w_is_mem ? bus.i_dunit_mem_data : bus.i_dunit_reg;
                w_next    = DUMP_TX;
            end
            DUMP_TX: if (w_done) begin
                if (w_last_idx) begin
                    w_start   = 1'b1;
                    w_single  = 1'b1;
                    w_tx_word = NB_REG'(bus.i_halt ? TRAIL_HALT : TRAIL_RUN);
                    w_next    = SEND_BYTE;
                end else begin
                    w_next = DUMP_ADDR;
                end
            end
            SEND_BYTE: if (w_done) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.o_dunit_clk_en   = (r_state == RUN) || (r_state == STEP);
        bus.o_dunit_w_mem    = (r_state == LOAD_WRITE);
        bus.o_dunit_reset_pc = (r_state == RST_PC);
        bus.o_dunit_data_if  = '0;
        bus.o_dunit_addr     = '0;
        if (r_state == LOAD_WRITE) begin
            bus.o_dunit_addr    = word_addr(NB_REG'(r_word_cnt));
            bus.o_dunit_data_if = r_word;
        end else if (r_state == DUMP_ADDR || r_state == DUMP_WAIT) begin
            bus.o_dunit_addr = w_dump_addr;
        end
    end

    // Datapath counters; IDLE re-arms them so every command starts from a clean slate.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_word_cnt <= '0;
            r_len      <= '0;
            r_byte_cnt <= 2'd0;
            r_word     <= '0;
            r_idx      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_word_cnt <= '0;
                    r_byte_cnt <= 2'd0;
                    r_idx      <= '0;
                end
                LOAD_LEN: if (bus.i_rx_valid) r_len <= NB_WCNT'(bus.i_rx_data);
                LOAD_BYTE: if (bus.i_rx_valid) begin
                    r_word     <= {r_word[NB_REG-NB_BYTE-1:0], bus.i_rx_data};
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end
                LOAD_WRITE: r_word_cnt <= r_word_cnt + 1'b1;
                DUMP_TX: if (w_done && !w_last_idx) r_idx <= r_idx + 1'b1;
                default: ;
            endcase
        end
    end

    dbg_word_tx u_word_tx (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (w_start),
        .i_single   (w_single),
        .i_word     (w_tx_word),
        .i_tx_ready (bus.i_tx_ready),
        .o_tx_data  (bus.o_tx_data),
        .o_tx_valid (bus.o_tx_valid),
        .o_done     (w_done)
    );

    assign o_state = r_state;

endmodule

// File: doc/debug_unit_ctrl.md
Name: debug_unit_ctrl

Overview:
- Command sequencer between a byte-stream link (UART RX/TX wrappers, valid/ready bytes) and the debug port of the 5-stage MIPS pipeline.
- Loads the instruction memory and resets the PC.
- Runs the pipeline continuously until halt, or single-steps it, by gating the pipeline clock enable.
- After every run or step, dumps the register file and the data memory back over the link.

Parameters:
NB_REG, 32, pipeline data/address width
NB_BYTE, 8, link byte width
N_INST_WORDS, 128, maximum program length in 32-bit words
N_REGS, 32, registers dumped
N_MEM_WORDS, 32, data-memory words dumped (128 bytes)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid
o_tx_data  out  8  byte to transmit
o_tx_valid  out  1  o_tx_data is valid; held until accepted
i_tx_ready  in  1  transmitter accepts o_tx_data when o_tx_valid and i_tx_ready are both 1
i_halt  in  1  pipeline halt (HALT instruction reached WB)
i_dunit_reg  in  NB_REG  register-file read data
i_dunit_mem_data  in  NB_REG  data-memory read data
o_dunit_clk_en  out  1  pipeline clock enable
o_dunit_reset_pc  out  1  PC reset pulse
o_dunit_w_mem  out  1  instruction-memory write strobe
o_dunit_addr  out  NB_REG  shared debug address
o_dunit_data_if  out  NB_REG  instruction word to write
o_state  out  4  current FSM state, for LEDs

Behaviour:
- Reset (i_reset=0, at any time, including mid-run or mid-dump):
  - state=IDLE.
  - All outputs 0, including o_dunit_clk_en. Counters cleared.
- Command bytes, accepted only in IDLE:
  - 'L' (0x4C) load program.
  - 'C' (0x43) continuous run.
  - 'S' (0x53) single step.
  - 'R' (0x52) reset PC.
  - Any other byte: send NAK 0x15, stay in IDLE.
- All link bytes are transmitted through a single path. Words are always sent MSB first.
- LOAD:
  - LOAD_LEN: the next rx byte is N.
    - N=0 or N>N_INST_WORDS: send NAK, go to IDLE.
  - LOAD_BYTE: collect 4 bytes, MSB first, into a word.
  - LOAD_WRITE: one cycle with o_dunit_w_mem=1, o_dunit_addr=4*k, o_dunit_data_if=word; then k++.
  - After word N-1: one-cycle o_dunit_reset_pc=1, send ACK 0xAA, go to IDLE.
  - o_dunit_clk_en stays 0 throughout LOAD.
- 'R': one-cycle o_dunit_reset_pc=1, then ACK, then IDLE.
- RUN ('C'):
  - If i_halt=1 on entry: go straight to DUMP.
  - Otherwise hold o_dunit_clk_en=1 until i_halt=1 is sampled; clk_en drops in the following cycle; go to DUMP.
  - An rx byte 'X' (0x58) during RUN aborts: clk_en drops the next cycle, then DUMP.
  - All other rx bytes during RUN are dropped.
- STEP ('S'):
  - o_dunit_clk_en=1 for exactly one cycle, then DUMP.
  - If i_halt=1 on entry: no clk_en pulse; DUMP only.
- DUMP: for idx 0..N_REGS-1 (registers), then 0..N_MEM_WORDS-1 (memory):
  - DUMP_ADDR: drive o_dunit_addr (register index, or byte address 4*idx for memory).
  - DUMP_WAIT: one cycle of read latency.
  - Capture the word (i_dunit_reg or i_dunit_mem_data).
  - DUMP_TX: send 4 bytes.
  - After the last memory word: send a trailer byte, 0x48 if i_halt=1 else 0x53; go to IDLE.
  - Total dump length: 4*(N_REGS+N_MEM_WORDS)+1 = 257 bytes.
  - rx bytes during DUMP are dropped.
- TX handshake:
  - o_tx_valid and o_tx_data are stable until the accepting cycle.
  - The next byte is presented no earlier than the cycle after acceptance.
  - i_tx_ready held low stalls the FSM indefinitely, with no loss or duplication.
- Pipeline isolation: o_dunit_clk_en=0 in every state except RUN and STEP.
- o_dunit_w_mem is never 1 together with o_dunit_clk_en.
- Counter widths:
  - Word counter: $clog2(N_INST_WORDS+1) bits.
  - Byte counter: 2 bits, wraps 3→0.
- Unused o_dunit_addr bits are 0.

Decomposition:
- Shared package dbg_pkg holds:
  - Command codes 'L', 'C', 'S', 'R', 'X'.
  - ACK 0xAA, NAK 0x15, trailer codes 0x48/0x53.
  - FSM state enum (IDLE, LOAD_LEN, LOAD_BYTE, LOAD_WRITE, RST_PC, RUN, STEP, DUMP_ADDR, DUMP_WAIT, DUMP_TX, SEND_BYTE).
- Sub-module dbg_word_tx: 32-bit word to 4-byte serializer with the valid/ready handshake and a done pulse. It is reused for dump words; single ACK/NAK/trailer bytes use its 1-byte mode.

Test Plan:
- 'L', 0x02, then 00 00 00 01 and FF FF FF FE:
  - Two w_mem pulses with addr 0/data 0x00000001, then addr 4/data 0xFFFFFFFE.
  - One reset_pc pulse, then tx 0xAA.
  - clk_en=0 throughout.
- 'L', 0x00 → tx 0x15, no w_mem. Unknown byte 0x7A in IDLE → tx 0x15.
- 'S' with i_halt=0:
  - clk_en high for exactly 1 cycle.
  - 257 bytes follow; bytes 4..7 equal model reg[1].
  - Trailer 0x53.
- 'C' with i_halt asserted 50 cycles later:
  - clk_en high for 50 cycles, then low.
  - Dump ends with 0x48.
  - Repeat with 'X' sent at cycle 20: clk_en drops at cycle 21 and a dump follows.
- Randomized i_tx_ready (30% high) during a dump → byte stream identical to the ready-always-high run.
- Assert i_reset=0 mid-RUN and mid-DUMP:
  - clk_en=0 and tx_valid=0 immediately (asynchronous).
  - IDLE after release; the next 'R' gives reset_pc pulse + 0xAA.
